// File: rtl/uart_tx.sv
// ============================================================================
// Module   : uart_tx
// Brief    : UART transmitter, 8 data bits + parity + 1 stop bit, LSB first.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx #(
    parameter int CLK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE     = 19_200,
    parameter bit PARITY        = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] din,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);

    localparam int c_BAUD_CYCLES = CLK_FREQUENCY / BAUD_RATE;
    localparam int c_CNT_W       = (c_BAUD_CYCLES > 1) ? $clog2(c_BAUD_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_BAUD_LAST = c_CNT_W'(c_BAUD_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_PAR   = 3'd3,
        S_STOP  = 3'd4
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_baud_cnt;
    logic [c_CNT_W-1:0]   w_baud_next;
    logic [2:0]           r_bit_cnt;
    logic [2:0]           w_bit_next;
    logic [7:0]           r_shift;
    logic [7:0]           w_shift_next;
    logic                 r_par;
    logic                 w_par_next;
    logic                 r_tx;
    logic                 w_tx_next;
    logic                 w_wrap;

    assign w_wrap = (r_baud_cnt == c_BAUD_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_par      <= 1'b0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_next;
            r_baud_cnt <= w_baud_next;
            r_bit_cnt  <= w_bit_next;
            r_shift    <= w_shift_next;
            r_par      <= w_par_next;
            r_tx       <= w_tx_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud_cnt;
        w_bit_next   = r_bit_cnt;
        w_shift_next = r_shift;
        w_par_next   = r_par;

        if (r_state != S_IDLE) begin
            w_baud_next = w_wrap ? '0 : r_baud_cnt + 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (send) begin
                    w_state_next = S_START;
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_shift_next = din;
                    w_par_next   = (^din) ^ PARITY;
                end
            end
            S_START: begin
                if (w_wrap) begin
                    w_state_next = S_DATA;
                    w_bit_next   = '0;
                end
            end
            S_DATA: begin
                if (w_wrap) begin
                    w_shift_next = {1'b0, r_shift[7:1]};
                    if (r_bit_cnt == 3'd7) begin
                        w_state_next = S_PAR;
                        w_bit_next   = '0;
                    end else begin
                        w_bit_next = r_bit_cnt + 3'd1;
                    end
                end
            end
            S_PAR: begin
                if (w_wrap) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                if (w_wrap) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
                w_baud_next  = '0;
                w_bit_next   = '0;
            end
        endcase
    end

    // Line level is decided from the next state so tx_out comes straight off a flop.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START: w_tx_next = 1'b0;
            S_DATA:  w_tx_next = w_shift_next[0];
            S_PAR:   w_tx_next = w_par_next;
            default: w_tx_next = 1'b1;
        endcase
    end

    assign tx_out = r_tx;
    assign busy   = (r_state != S_IDLE);
    assign done   = (r_state == S_STOP) && w_wrap;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx.sv
// ============================================================================
// Module   : tb_uart_tx
// Brief    : Self-checking bench for uart_tx (odd and even parity instances).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_tx;

    localparam int c_BAUD  = 10;
    localparam int c_FRAME = 11 * c_BAUD;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       send = 1'b0;
    logic [7:0] din = 8'h00;
    logic       tx_out [2];
    logic       busy   [2];
    logic       done   [2];

    int checks = 0;
    int errors = 0;
    int done_cnt [2] = '{0, 0};

    logic [c_FRAME-1:0] cap_tx   [2];
    logic [c_FRAME-1:0] cap_busy [2];
    logic [c_FRAME-1:0] cap_done [2];

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .PARITY(1'b1)) u_odd (
        .clk(clk), .rst(rst), .send(send), .din(din),
        .tx_out(tx_out[0]), .busy(busy[0]), .done(done[0]));

    uart_tx #(.CLK_FREQUENCY(1_000_000), .BAUD_RATE(100_000), .PARITY(1'b0)) u_even (
        .clk(clk), .rst(rst), .send(send), .din(din),
        .tx_out(tx_out[1]), .busy(busy[1]), .done(done[1]));

    always @(posedge clk) begin
        if (done[0]) done_cnt[0] <= done_cnt[0] + 1;
        if (done[1]) done_cnt[1] <= done_cnt[1] + 1;
    end

    typedef struct {
        logic [7:0] d;
        logic       par_odd;
        logic       par_even;
    } vec_t;

    // Reference frame: start, d0..d7, parity, stop; bit k of the result is line bit k.
    function automatic logic [10:0] frame_bits(input logic [7:0] d, input logic odd);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        return {1'b1, logic'((ones % 2 == 0) ? odd : !odd), d, 1'b0};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Samples one frame's worth of cycles, starting the cycle after the accepting edge.
    task automatic capture();
        for (int i = 0; i < c_FRAME; i++) begin
            @(negedge clk);
            for (int u = 0; u < 2; u++) begin
                cap_tx[u][i]   = tx_out[u];
                cap_busy[u][i] = busy[u];
                cap_done[u][i] = done[u];
            end
        end
    endtask

    task automatic verify(input string name, input logic [7:0] d);
        logic [c_FRAME-1:0] e_tx;
        logic [c_FRAME-1:0] e_done;
        logic [10:0]        f;
        logic [7:0]         rx;
        for (int u = 0; u < 2; u++) begin
            f = frame_bits(d, (u == 0));
            e_done = '0;
            e_done[c_FRAME-1] = 1'b1;
            for (int i = 0; i < c_FRAME; i++) e_tx[i] = f[i / c_BAUD];
            for (int b = 0; b < 8; b++) rx[b] = cap_tx[u][(b + 1) * c_BAUD + c_BAUD / 2];
            chk($sformatf("%s_tx_u%0d", name, u), 128'(cap_tx[u]), 128'(e_tx));
            chk($sformatf("%s_busy_u%0d", name, u), 128'(cap_busy[u]), 128'({c_FRAME{1'b1}}));
            chk($sformatf("%s_done_u%0d", name, u), 128'(cap_done[u]), 128'(e_done));
            chk($sformatf("%s_rxbyte_u%0d", name, u), 128'(rx), 128'(d));
        end
    endtask

    task automatic check_idle(input string name);
        for (int u = 0; u < 2; u++) begin
            chk($sformatf("%s_idle_u%0d", name, u), 128'({tx_out[u], busy[u], done[u]}), 128'(3'b100));
        end
    endtask

    task automatic pulse_send(input logic [7:0] d);
        @(negedge clk);
        send = 1'b1;
        din  = d;
        @(posedge clk);
        #1 send = 1'b0;
    endtask

    vec_t vecs [11];
    int   quiet;
    int   snap [2];
    logic [7:0] rb;

    initial begin
        vecs = '{
            '{8'h55, 1'b1, 1'b0}, '{8'h01, 1'b0, 1'b1}, '{8'hFF, 1'b1, 1'b0},
            '{8'h00, 1'b1, 1'b0}, '{8'h7E, 1'b1, 1'b0}, '{8'h81, 1'b1, 1'b0},
            '{8'hA5, 1'b1, 1'b0}, '{8'h3C, 1'b1, 1'b0}, '{8'h12, 1'b1, 1'b0},
            '{8'h80, 1'b0, 1'b1}, '{8'h07, 1'b0, 1'b1}};

        repeat (3) @(negedge clk);
        check_idle("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle("post_reset");

        // Table: full frame against the model plus hand-computed parity bits.
        for (int v = 0; v < 11; v++) begin
            pulse_send(vecs[v].d);
            capture();
            verify($sformatf("vec%0d", v), vecs[v].d);
            chk($sformatf("vec%0d_par_odd", v), 128'(cap_tx[0][9 * c_BAUD + 5]), 128'(vecs[v].par_odd));
            chk($sformatf("vec%0d_par_even", v), 128'(cap_tx[1][9 * c_BAUD + 5]), 128'(vecs[v].par_even));
            @(negedge clk);
            check_idle($sformatf("vec%0d_after", v));
        end

        // send held high: back-to-back frames with exactly one idle cycle between.
        @(negedge clk);
        send = 1'b1;
        din  = 8'hA5;
        @(posedge clk);
        #1 din = 8'h3C;
        capture();
        verify("hold_a5", 8'hA5);
        @(negedge clk);
        check_idle("hold_gap");
        capture();
        send = 1'b0;
        verify("hold_3c", 8'h3C);
        @(negedge clk);
        check_idle("hold_end");

        // A request during a frame is dropped, not queued.
        pulse_send(8'h12);
        fork
            capture();
            begin
                repeat (50) @(negedge clk);
                send = 1'b1;
                din  = 8'h34;
                @(negedge clk);
                send = 1'b0;
            end
        join
        verify("busy_ignore", 8'h12);
        quiet = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy[0] || busy[1] || !tx_out[0] || !tx_out[1]) quiet++;
        end
        chk("busy_ignore_no_requeue", 128'(quiet), 128'(0));

        // Reset mid-frame.
        snap = done_cnt;
        pulse_send(8'hC3);
        repeat (40) @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle("midframe_rst");
        repeat (3) @(negedge clk);
        check_idle("midframe_rst_hold");
        chk("midframe_no_done_u0", 128'(done_cnt[0]), 128'(snap[0]));
        chk("midframe_no_done_u1", 128'(done_cnt[1]), 128'(snap[1]));
        rst = 1'b0;
        repeat (2) @(negedge clk);
        pulse_send(8'h96);
        capture();
        verify("after_rst", 8'h96);

        // Random bytes with random idle gaps.
        for (int n = 0; n < 16; n++) begin
            repeat ($urandom_range(0, 5)) @(negedge clk);
            rb = 8'($urandom);
            pulse_send(rb);
            capture();
            verify($sformatf("rand%0d", n), rb);
        end

        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
